// File: rtl/write_back_pkg.sv
// Shared definitions for the writeback stage: opcodes, bubble encoding, register-file
// geometry, counter width and the writeback-source select helper.
package write_back_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned NumRegs  = 32;
  localparam int unsigned RegAddrW = 5;
  localparam int unsigned CNT_W    = 64;

  localparam logic [6:0]      OPC_JAL   = 7'b1101111;
  localparam logic [6:0]      OPC_JALR  = 7'b1100111;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    SelAlu,
    SelLoad,
    SelLink
  } wb_sel_e;

  // Jumps write the link address even when flagged as loads, so they are tested first.
  function automatic wb_sel_e wb_select(input logic [6:0] opcode, input logic is_load);
    if (opcode == OPC_JAL || opcode == OPC_JALR) begin
      return SelLink;
    end else if (is_load) begin
      return SelLoad;
    end
    return SelAlu;
  endfunction

endpackage

// File: rtl/write_back_regfile.sv
// 32x32 integer register file.
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset (clears x1..x31)
//   we_i/waddr_i/wdata_i synchronous write port; writes to x0 are dropped
//   raddr1_i/rdata1_o    combinational read port 1 (x0 reads 0)
//   raddr2_i/rdata2_o    combinational read port 2 (x0 reads 0)
// A read of a register being written in the same cycle returns the old contents.
module write_back_regfile
  import write_back_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                we_i,
  input  logic [RegAddrW-1:0] waddr_i,
  input  logic [XLEN-1:0]     wdata_i,
  input  logic [RegAddrW-1:0] raddr1_i,
  input  logic [RegAddrW-1:0] raddr2_i,
  output logic [XLEN-1:0]     rdata1_o,
  output logic [XLEN-1:0]     rdata2_o
);

  // x0 has no storage at all.
  logic [XLEN-1:0] regs_q [1:NumRegs-1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 1; i < NumRegs; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != '0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = (raddr1_i == '0) ? '0 : regs_q[raddr1_i];
  assign rdata2_o = (raddr2_i == '0) ? '0 : regs_q[raddr2_i];

endmodule

// File: rtl/write_back.sv
// Writeback pipeline stage.
// Registers the memory-access outputs, selects the writeback value (link address, load data
// or ALU result), writes it into the register file and serves decode's two read ports.
// Also keeps a free-running cycle counter and a retired-instruction counter.
// Ports:
//   clk, rst                    clock, asynchronous active-low reset
//   mem_*                       memory-access stage outputs
//   id_rs1/2_num, id_rs1/2_value decode register reads (combinational)
//   wb_*                        registered stage outputs used for execute forwarding
//   hc_value, hc_value_hi       cycle counter low/high words
//   retired_cnt                 retired-instruction counter
module write_back
  import write_back_pkg::*;
#(
  parameter logic [XLEN-1:0] NopInstr = NOP_INSTR,
  parameter int unsigned     CntW     = CNT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [XLEN-1:0]     mem_instr,
  input  logic [RegAddrW-1:0] mem_dstreg_num,
  input  logic                mem_reg_we,
  input  logic                mem_is_load,
  input  logic [6:0]          mem_opcode,
  input  logic [XLEN-1:0]     mem_PC,
  input  logic [XLEN-1:0]     mem_alu_result,
  input  logic [XLEN-1:0]     mem_load_value,
  input  logic [RegAddrW-1:0] id_rs1_num,
  input  logic [RegAddrW-1:0] id_rs2_num,
  output logic [XLEN-1:0]     id_rs1_value,
  output logic [XLEN-1:0]     id_rs2_value,
  output logic [RegAddrW-1:0] wb_dstreg_num,
  output logic                wb_reg_we,
  output logic [XLEN-1:0]     wb_value,
  output logic [XLEN-1:0]     wb_PC,
  output logic [XLEN-1:0]     wb_instr,
  output logic [XLEN-1:0]     hc_value,
  output logic [XLEN-1:0]     hc_value_hi,
  output logic [XLEN-1:0]     retired_cnt
);

  logic [XLEN-1:0]     wb_value_d, wb_value_q;
  logic [XLEN-1:0]     wb_instr_q, wb_pc_q;
  logic [RegAddrW-1:0] wb_dst_q;
  logic                wb_we_d, wb_we_q;
  logic [CntW-1:0]     cyc_d, cyc_q;
  logic [XLEN-1:0]     ret_d, ret_q;
  logic                retire;

  // x0 writes are squashed before the register so forwarding never sees them.
  assign wb_we_d = mem_reg_we && (mem_dstreg_num != '0);
  assign retire  = (mem_instr != NopInstr) && (mem_instr != '0);

  always_comb begin
    wb_value_d = mem_alu_result;
    unique case (wb_select(mem_opcode, mem_is_load))
      SelLink: wb_value_d = mem_PC + 32'd4;
      SelLoad: wb_value_d = mem_load_value;
      default: wb_value_d = mem_alu_result;
    endcase
  end

  assign cyc_d = cyc_q + CntW'(1);
  assign ret_d = retire ? ret_q + 32'd1 : ret_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_instr_q <= NopInstr;
      wb_pc_q    <= '0;
      wb_dst_q   <= '0;
      wb_we_q    <= 1'b0;
      wb_value_q <= '0;
      cyc_q      <= '0;
      ret_q      <= '0;
    end else begin
      wb_instr_q <= mem_instr;
      wb_pc_q    <= mem_PC;
      wb_dst_q   <= mem_dstreg_num;
      wb_we_q    <= wb_we_d;
      wb_value_q <= wb_value_d;
      cyc_q      <= cyc_d;
      ret_q      <= ret_d;
    end
  end

  write_back_regfile u_regfile (
    .clk_i    (clk),
    .rst_ni   (rst),
    .we_i     (wb_we_d),
    .waddr_i  (mem_dstreg_num),
    .wdata_i  (wb_value_d),
    .raddr1_i (id_rs1_num),
    .raddr2_i (id_rs2_num),
    .rdata1_o (id_rs1_value),
    .rdata2_o (id_rs2_value)
  );

  assign wb_instr      = wb_instr_q;
  assign wb_PC         = wb_pc_q;
  assign wb_dstreg_num = wb_dst_q;
  assign wb_reg_we     = wb_we_q;
  assign wb_value      = wb_value_q;
  assign hc_value      = cyc_q[31:0];
  assign hc_value_hi   = cyc_q[63:32];
  assign retired_cnt   = ret_q;

endmodule

// File: tb/tb_write_back.sv
// Bench for write_back: directed steps plus randomized vectors checked against a
// reference model of the stage (array register file, integer counters).
module tb_write_back;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] mem_instr = 32'h13;
  logic [4:0]  mem_dstreg_num = '0;
  logic        mem_reg_we = 1'b0;
  logic        mem_is_load = 1'b0;
  logic [6:0]  mem_opcode = 7'h13;
  logic [31:0] mem_PC = '0;
  logic [31:0] mem_alu_result = '0;
  logic [31:0] mem_load_value = '0;
  logic [4:0]  id_rs1_num = '0;
  logic [4:0]  id_rs2_num = '0;
  logic [31:0] id_rs1_value, id_rs2_value;
  logic [4:0]  wb_dstreg_num;
  logic        wb_reg_we;
  logic [31:0] wb_value, wb_PC, wb_instr, hc_value, hc_value_hi, retired_cnt;

  write_back dut (
    .clk            (clk),
    .rst            (rst),
    .mem_instr      (mem_instr),
    .mem_dstreg_num (mem_dstreg_num),
    .mem_reg_we     (mem_reg_we),
    .mem_is_load    (mem_is_load),
    .mem_opcode     (mem_opcode),
    .mem_PC         (mem_PC),
    .mem_alu_result (mem_alu_result),
    .mem_load_value (mem_load_value),
    .id_rs1_num     (id_rs1_num),
    .id_rs2_num     (id_rs2_num),
    .id_rs1_value   (id_rs1_value),
    .id_rs2_value   (id_rs2_value),
    .wb_dstreg_num  (wb_dstreg_num),
    .wb_reg_we      (wb_reg_we),
    .wb_value       (wb_value),
    .wb_PC          (wb_PC),
    .wb_instr       (wb_instr),
    .hc_value       (hc_value),
    .hc_value_hi    (hc_value_hi),
    .retired_cnt    (retired_cnt)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Reference model state.
  logic [31:0] m_regs [32];
  logic [63:0] m_cyc;
  logic [31:0] m_ret;
  logic [31:0] e_instr, e_pc, e_val;
  logic [4:0]  e_dst;
  logic        e_we;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_cyc = '0; m_ret = '0;
    e_instr = 32'h13; e_pc = '0; e_val = '0; e_dst = '0; e_we = 1'b0;
  endtask

  // One clock edge of the stage as described at the architectural level.
  task automatic model_edge();
    logic [31:0] v;
    if (mem_opcode == 7'b1101111 || mem_opcode == 7'b1100111) v = mem_PC + 32'd4;
    else if (mem_is_load) v = mem_load_value;
    else v = mem_alu_result;
    e_instr = mem_instr; e_pc = mem_PC; e_dst = mem_dstreg_num; e_val = v;
    e_we = mem_reg_we && (mem_dstreg_num != 5'd0);
    if (e_we) m_regs[mem_dstreg_num] = v;
    m_cyc = m_cyc + 64'd1;
    if (mem_instr != 32'h13 && mem_instr != 32'h0) m_ret = m_ret + 32'd1;
  endtask

  task automatic chk_out(input string tg);
    chk({tg, ".wb_instr"}, wb_instr, e_instr);
    chk({tg, ".wb_PC"}, wb_PC, e_pc);
    chk({tg, ".wb_dst"}, wb_dstreg_num, e_dst);
    chk({tg, ".wb_we"}, wb_reg_we, e_we);
    chk({tg, ".wb_value"}, wb_value, e_val);
    chk({tg, ".hc_lo"}, hc_value, m_cyc[31:0]);
    chk({tg, ".hc_hi"}, hc_value_hi, m_cyc[63:32]);
    chk({tg, ".retired"}, retired_cnt, m_ret);
    chk({tg, ".rs1"}, id_rs1_value, m_regs[id_rs1_num]);
    chk({tg, ".rs2"}, id_rs2_value, m_regs[id_rs2_num]);
  endtask

  // Check reads before the edge (old contents), clock once, check everything after.
  task automatic cycle(input string tg);
    #1;
    chk({tg, ".rs1_pre"}, id_rs1_value, m_regs[id_rs1_num]);
    chk({tg, ".rs2_pre"}, id_rs2_value, m_regs[id_rs2_num]);
    @(posedge clk);
    model_edge();
    #1;
    chk_out(tg);
  endtask

  task automatic drive(input logic [31:0] instr, input logic [6:0] opc, input logic [4:0] dst,
                       input logic we, input logic ld, input logic [31:0] pc,
                       input logic [31:0] alu, input logic [31:0] lv);
    mem_instr = instr; mem_opcode = opc; mem_dstreg_num = dst; mem_reg_we = we;
    mem_is_load = ld; mem_PC = pc; mem_alu_result = alu; mem_load_value = lv;
  endtask

  task automatic apply_reset(input string tg);
    rst = 1'b0;
    #1;
    model_reset();
    chk_out(tg);
    @(negedge clk);
    #2 rst = 1'b1;
  endtask

  initial begin
    logic [31:0] cnt_instrs [10];
    cnt_instrs = '{32'h00500093, 32'h13, 32'h002081b3, 32'h0, 32'h13, 32'h00112023,
                   32'h0000006f, 32'h13, 32'h40000033, 32'hfff00113};

    #2;
    apply_reset("reset0");

    // ALU writeback to x3.
    id_rs1_num = 5'd3;
    drive(32'h00000033, 7'b0110011, 5'd3, 1'b1, 1'b0, 32'h10, 32'h12345678, 32'h0);
    cycle("alu");
    chk("alu.value", wb_value, 32'h12345678);
    chk("alu.rs1", id_rs1_value, 32'h12345678);

    // Load beats ALU result.
    drive(32'h00002083, 7'b0000011, 5'd1, 1'b1, 1'b1, 32'h14, 32'h100, 32'hFFFFFF80);
    cycle("load");
    chk("load.value", wb_value, 32'hFFFFFF80);

    // JAL writes PC+4 to rd.
    id_rs2_num = 5'd2;
    drive(32'h0000016f, 7'b1101111, 5'd2, 1'b1, 1'b0, 32'h40, 32'h999, 32'h0);
    cycle("jal");
    chk("jal.value", wb_value, 32'h44);
    chk("jal.rs2", id_rs2_value, 32'h44);

    // JALR at top of address space wraps the link address to 0.
    drive(32'h000000e7, 7'b1100111, 5'd1, 1'b1, 1'b1, 32'hFFFFFFFC, 32'h7, 32'h8);
    cycle("jalr_wrap");

    // x0 protection.
    id_rs1_num = 5'd0;
    drive(32'h05500013, 7'b0010011, 5'd0, 1'b1, 1'b0, 32'h50, 32'h55, 32'h0);
    cycle("x0");
    chk("x0.we", wb_reg_we, 1'b0);
    chk("x0.rs1", id_rs1_value, 32'h0);

    // Same-cycle read and write of x7.
    id_rs2_num = 5'd7;
    drive(32'h00100393, 7'b0010011, 5'd7, 1'b1, 1'b0, 32'h54, 32'h1, 32'h0);
    cycle("x7_old");
    drive(32'h00a00393, 7'b0010011, 5'd7, 1'b1, 1'b0, 32'h58, 32'hA, 32'h0);
    #1 chk("rw.before", id_rs2_value, 32'h1);
    cycle("x7_new");
    chk("rw.after", id_rs2_value, 32'hA);

    // Mid-run reset with counters nonzero and x5 holding data.
    id_rs1_num = 5'd5;
    drive(32'h00000293, 7'b0010011, 5'd5, 1'b1, 1'b0, 32'h5c, 32'hDEAD, 32'h0);
    cycle("x5");
    chk("x5.rs1", id_rs1_value, 32'hDEAD);
    drive(32'h13, 7'b0010011, 5'd0, 1'b0, 1'b0, 32'h60, 32'h0, 32'h0);
    #3;
    apply_reset("reset_mid");
    chk("reset_mid.x5", id_rs1_value, 32'h0);
    chk("reset_mid.instr", wb_instr, 32'h00000013);

    // Ten cycles: three NOPs and one all-zero word.
    for (int i = 0; i < 10; i++) begin
      drive(cnt_instrs[i], 7'b0010011, 5'(i), 1'b0, 1'b0, 32'(i * 4), 32'(i), 32'h0);
      cycle("cnt");
    end
    chk("cnt.hc", hc_value, 32'd10);
    chk("cnt.retired", retired_cnt, 32'd6);

    // Randomized vectors.
    for (int i = 0; i < 300; i++) begin
      logic [31:0] ins;
      logic [6:0]  opc;
      logic [31:0] pc;
      case ($urandom_range(0, 9))
        0: ins = 32'h13;
        1: ins = 32'h0;
        default: ins = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: opc = 7'b1101111;
        1: opc = 7'b1100111;
        default: opc = 7'($urandom);
      endcase
      pc = ($urandom_range(0, 15) == 0) ? 32'hFFFFFFFC : $urandom;
      id_rs1_num = 5'($urandom);
      id_rs2_num = 5'($urandom);
      drive(ins, opc, 5'($urandom), 1'($urandom), 1'($urandom), pc, $urandom, $urandom);
      cycle("rand");
    end

    // Carry from the low to the high cycle-counter word.
    drive(32'h13, 7'b0010011, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    force dut.cyc_d = 64'h0000_0000_FFFF_FFFF;
    m_cyc = 64'h0000_0000_FFFF_FFFE;
    cycle("preload");
    release dut.cyc_d;
    cycle("carry");
    chk("carry.lo", hc_value, 32'h0);
    chk("carry.hi", hc_value_hi, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
